// File: rtl/click_pkg.sv
// Shared types for the click-pipeline receiver: default token width, token type
// and the receive-side handshake state encoding.
package click_pkg;

    localparam int CLICK_DATA_W = 8;

    typedef logic [CLICK_DATA_W-1:0] click_data_t;

    typedef enum logic {
        RX_IDLE    = 1'b0,
        RX_PENDING = 1'b1
    } rx_state_t;

endpackage

// File: rtl/click_sync_receiver_if.sv
// Bundle of the 2-phase click input channel and the clocked valid/ready output channel.
// The slave side is the receiver; the master side is the upstream stage plus the downstream consumer.
interface click_sync_receiver_if
    import click_pkg::*;
#(
    parameter int DATA_W = CLICK_DATA_W
) ();

    logic              in_req;
    logic [DATA_W-1:0] in_data;
    logic              in_ack;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_req,
        output in_data,
        output out_ready,
        input  in_ack,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_req,
        input  in_data,
        input  out_ready,
        output in_ack,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset; q lags d by two clk edges.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability-settling flop chain
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/click_sync_receiver.sv
// Terminal consumer of a 2-phase bundled-data click pipeline: synchronises req, captures
// the bundled data into an FWFT FIFO and returns a 2-phase ack per accepted token.
module click_sync_receiver
    import click_pkg::*;
#(
    parameter int DATA_W = CLICK_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    click_sync_receiver_if.slave     bus,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         rx_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic              req_s;
    logic              ack_r;
    logic              ack_nxt_s;
    rx_state_t         rx_state_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [OCC_W-1:0]  occ_r;
    logic [OCC_W-1:0]  occ_nxt_s;
    logic              valid_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    sync_2ff #(
        .WIDTH (1)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.in_req),
        .q     (req_s)
    );

    assign full_s = (occ_r == OCC_W'(DEPTH));
    assign pop_s  = valid_r & bus.out_ready;

    // Handshake state register: ack_r is the only state held; it differs from req_s while a token waits
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= ack_nxt_s;
        end
    end

    // Next-state: decode the current state and toggle ack once a waiting token fits in the FIFO
    always_comb begin
        rx_state_s = RX_IDLE;
        ack_nxt_s  = ack_r;
        if (req_s != ack_r) begin
            rx_state_s = RX_PENDING;
        end else begin
            rx_state_s = RX_IDLE;
        end
        case (rx_state_s)
            RX_PENDING: begin
                if (!full_s) begin
                    ack_nxt_s = ~ack_r;
                end else begin
                    ack_nxt_s = ack_r;
                end
            end
            RX_IDLE:  ack_nxt_s = ack_r;
            default:  ack_nxt_s = ack_r;
        endcase
    end

    // Outputs of the handshake FSM: a FIFO write accompanies every ack toggle
    always_comb begin
        push_s = 1'b0;
        case (rx_state_s)
            RX_PENDING: push_s = ~full_s;
            RX_IDLE:    push_s = 1'b0;
            default:    push_s = 1'b0;
        endcase
    end

    // Fill-level update; a full FIFO refuses the write even when a pop frees a slot on the same edge
    always_comb begin
        occ_nxt_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + OCC_W'(1);
            2'b01:   occ_nxt_s = occ_r - OCC_W'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // FIFO pointers, fill level, registered valid flag and wrapping token counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
            valid_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                cnt_r    <= cnt_r + CNT_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            occ_r   <= occ_nxt_s;
            valid_r <= (occ_nxt_s != {OCC_W{1'b0}});
        end
    end

    // Token storage; contents need no reset because the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    assign bus.in_ack    = ack_r;
    assign bus.out_valid = valid_r;
    assign bus.out_data  = mem_r[rd_ptr_r];
    assign occupancy     = occ_r;
    assign rx_count      = cnt_r;

endmodule

// File: tb/tb_click_sync_receiver.sv
// Directed bench for click_sync_receiver: stimulus pushes expected tokens into a queue,
// a negedge monitor pops and compares every token the DUT hands downstream.
module tb_click_sync_receiver;
    import click_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] rx_count;

    int total = 0;
    int bad   = 0;
    click_data_t exp_q [$];
    logic lvl;

    click_sync_receiver_if #(.DATA_W(CLICK_DATA_W)) bus_if ();

    click_sync_receiver #(
        .DATA_W (CLICK_DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .occupancy (occupancy),
        .rx_count  (rx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: the head is consumed at the next posedge when valid & ready
    always @(negedge clk) begin
        if (!reset && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got 0x%0h expected no token", bus_if.out_data);
            end else begin
                chk("pop_data", {24'h0, bus_if.out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_nowait(input click_data_t d);
        bus_if.in_data = d;
        bus_if.in_req  = ~bus_if.in_req;
        exp_q.push_back(d);
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        while (bus_if.in_ack !== bus_if.in_req && n < 40) begin
            tick(1);
            n++;
        end
        chk(name, {31'h0, bus_if.in_ack}, {31'h0, bus_if.in_req});
    endtask

    task automatic send(input click_data_t d);
        send_nowait(d);
        wait_ack("ack_timeout");
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus_if.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        chk(name, exp_q.size(), 32'd0);
        bus_if.out_ready = 1'b0;
        chk({name, "_valid"}, {31'h0, bus_if.out_valid}, 32'd0);
    endtask

    task automatic reset_dut();
        reset            = 1'b1;
        bus_if.in_req    = 1'b0;
        bus_if.out_ready = 1'b0;
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        bus_if.in_req    = 1'b0;
        bus_if.in_data   = 8'h00;
        bus_if.out_ready = 1'b0;

        // 1: reset state
        tick(2);
        chk("rst_ack",   {31'h0, bus_if.in_ack},    32'd0);
        chk("rst_valid", {31'h0, bus_if.out_valid}, 32'd0);
        chk("rst_occ",   {29'h0, occupancy},        32'd0);
        chk("rst_cnt",   {28'h0, rx_count},         32'd0);
        reset = 1'b0;
        tick(1);
        chk("post_rst_ack", {31'h0, bus_if.in_ack}, 32'd0);

        // 2: single token, ack on the third edge
        send_nowait(8'h01);
        tick(2);
        chk("lat_ack_e2",   {31'h0, bus_if.in_ack},    32'd0);
        chk("lat_valid_e2", {31'h0, bus_if.out_valid}, 32'd0);
        tick(1);
        chk("lat_ack_e3",   {31'h0, bus_if.in_ack},    32'd1);
        chk("lat_valid_e3", {31'h0, bus_if.out_valid}, 32'd1);
        chk("lat_data_e3",  {24'h0, bus_if.out_data},  32'h01);
        chk("lat_cnt_e3",   {28'h0, rx_count},         32'd1);
        chk("lat_occ_e3",   {29'h0, occupancy},        32'd1);
        bus_if.out_ready = 1'b1;
        tick(1);
        bus_if.out_ready = 1'b0;
        chk("pop1_valid", {31'h0, bus_if.out_valid}, 32'd0);
        chk("pop1_occ",   {29'h0, occupancy},        32'd0);

        // 3: back-pressure, fifth token waits for the first pop
        reset_dut();
        for (int i = 1; i <= 4; i++) send(click_data_t'(i));
        chk("bp_occ4", {29'h0, occupancy}, 32'd4);
        chk("bp_cnt4", {28'h0, rx_count},  32'd4);
        lvl = bus_if.in_ack;
        send_nowait(8'h05);
        tick(4);
        chk("bp_ack_hold", {31'h0, bus_if.in_ack}, {31'h0, lvl});
        chk("bp_occ_full", {29'h0, occupancy},     32'd4);
        chk("bp_cnt_hold", {28'h0, rx_count},      32'd4);
        bus_if.out_ready = 1'b1;
        tick(1);
        chk("bp_ack_popedge", {31'h0, bus_if.in_ack}, {31'h0, lvl});
        chk("bp_occ_popedge", {29'h0, occupancy},     32'd3);
        tick(1);
        chk("bp_ack_next", {31'h0, bus_if.in_ack}, {31'h0, ~lvl});
        chk("bp_cnt5",     {28'h0, rx_count},      32'd5);
        chk("bp_occ_next", {29'h0, occupancy},     32'd3);
        drain("bp_drain");

        // 4: steady stream at occupancy 1, push and pop on the same edge
        reset_dut();
        send(8'h20);
        chk("st_occ_pre", {29'h0, occupancy}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            send_nowait(click_data_t'(8'h20 + k));
            tick(2);
            bus_if.out_ready = 1'b1;
            tick(1);
            bus_if.out_ready = 1'b0;
            chk("st_occ", {29'h0, occupancy}, 32'd1);
            chk("st_ack", {31'h0, bus_if.in_ack}, {31'h0, bus_if.in_req});
        end
        drain("st_drain");

        // 5: reset with two tokens stored and a third pending
        reset_dut();
        send(8'hA1);
        send(8'hA2);
        chk("mr_occ2", {29'h0, occupancy}, 32'd2);
        send_nowait(8'hA3);
        tick(2);
        reset = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'hA3);
        tick(2);
        chk("mr_occ_rst",   {29'h0, occupancy},        32'd0);
        chk("mr_ack_rst",   {31'h0, bus_if.in_ack},    32'd0);
        chk("mr_valid_rst", {31'h0, bus_if.out_valid}, 32'd0);
        chk("mr_cnt_rst",   {28'h0, rx_count},         32'd0);
        reset = 1'b0;
        tick(2);
        chk("mr_ack_e2", {31'h0, bus_if.in_ack}, 32'd0);
        tick(1);
        chk("mr_ack_e3", {31'h0, bus_if.in_ack}, 32'd1);
        chk("mr_cnt_e3", {28'h0, rx_count},      32'd1);
        chk("mr_occ_e3", {29'h0, occupancy},     32'd1);
        drain("mr_drain");

        // 6: 17 tokens through a 4-bit counter
        reset_dut();
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(click_data_t'(8'h40 + i));
        chk("wrap_cnt", {28'h0, rx_count}, 32'd1);
        drain("wrap_drain");

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
